priority_request_latch: RTL and testbench

PRIORITY_REQUEST_LATCH -- requirements
Module: priority_request_latch

---
 rtl/priority_request_latch_pkg.sv | 8 +
 rtl/priority_request_latch_if.sv | 8 +
 rtl/priority_request_latch_enc.sv | 11 +
 rtl/priority_request_latch.sv | 53 +++++
 tb/tb_priority_request_latch.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/priority_request_latch_pkg.sv
// priority_request_latch_pkg: shared FSM state type and request code constants
package priority_request_latch_pkg;
  typedef enum logic {IDLE, OFFER} state_t;
  localparam logic [1:0] CODE_A = 2'b11;
  localparam logic [1:0] CODE_B = 2'b10;
  localparam logic [1:0] CODE_C = 2'b01;
  localparam logic [1:0] CODE_D = 2'b00;
endpackage

// File: rtl/priority_request_latch_if.sv
// priority_request_latch_if: request lines, offered code handshake and status
interface priority_request_latch_if;
  logic A, B, C, D;
  logic W, Y, VALID, READY, OVF;
  logic [3:0] PEND;
  modport master (output A, B, C, D, READY, input W, Y, VALID, OVF, PEND);
  modport slave (input A, B, C, D, READY, output W, Y, VALID, OVF, PEND);
endinterface

// File: rtl/priority_request_latch_enc.sv
// prio_enc4: 4-to-2 priority encoder over {A,B,C,D} with any-set flag
module prio_enc4
  import priority_request_latch_pkg::*;
(
  input  logic [3:0] pend,
  output logic [1:0] code,
  output logic       any
);
  assign code = pend[3] ? CODE_A : pend[2] ? CODE_B : pend[1] ? CODE_C : CODE_D;
  assign any = |pend;
endmodule

// File: rtl/priority_request_latch.sv
// priority_request_latch: synchronizes async request lines, latches rising edges, offers highest-priority code
module priority_request_latch
  import priority_request_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  priority_request_latch_if.slave bus
);
  logic [3:0] req, sync_q [SYNC_STAGES], prev_q, rise_q, pend_q, pend_d, pend_m, clr;
  logic [1:0] code_q, code_d, win;
  logic ovf_q, ovf_d, any, hs, load;
  state_t state_q, state_d;
  assign req = {bus.A, bus.B, bus.C, bus.D};
  prio_enc4 u_enc (.pend(pend_m), .code(win), .any(any));
  always_comb begin
    hs = state_q == OFFER && bus.READY;
    clr = hs ? 4'b0001 << code_q : 4'b0000;
    pend_m = pend_q & ~clr;
    // a new edge on a line being cleared this cycle re-arms it without overflow
    pend_d = pend_m | rise_q;
    ovf_d = ovf_q | |(rise_q & pend_m);
    load = state_q == IDLE || hs;
    state_d = load ? (any ? OFFER : IDLE) : state_q;
    code_d = load && any ? win : code_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      rise_q <= '0;
      pend_q <= '0;
      ovf_q <= 1'b0;
      code_q <= CODE_D;
      state_q <= IDLE;
    end else begin
      sync_q[0] <= req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      code_q <= code_d;
      state_q <= state_d;
    end
  end
  assign bus.VALID = state_q == OFFER;
  assign bus.W = code_q[1];
  assign bus.Y = code_q[0];
  assign bus.OVF = ovf_q;
  assign bus.PEND = pend_q;
endmodule

// File: tb/tb_priority_request_latch.sv
// tb_priority_request_latch: vector table, directed corner sequences and randomized model check
module tb_priority_request_latch;
  localparam int S = 2;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  priority_request_latch_if bus ();
  priority_request_latch #(.SYNC_STAGES(S)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [1:0] code;
  } vec_t;
  vec_t tbl [8];

  bit [3:0] hist [$];
  bit [3:0] m_pend;
  bit [1:0] m_code;
  bit m_valid, m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] p, input logic v, input logic o);
    chk({tag, " pend"}, {4'b0, bus.PEND}, {4'b0, p});
    chk({tag, " valid"}, {7'b0, bus.VALID}, {7'b0, v});
    chk({tag, " ovf"}, {7'b0, bus.OVF}, {7'b0, o});
  endtask

  task automatic chk_code(input string tag, input logic [1:0] c);
    chk({tag, " code"}, {6'b0, bus.W, bus.Y}, {6'b0, c});
  endtask

  task automatic drive(input logic [3:0] r);
    {bus.A, bus.B, bus.C, bus.D} = r;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rst();
    drive(4'b0000);
    bus.READY = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    hist = {};
    for (int i = 0; i < S + 3; i++) hist.push_back(4'b0);
    m_pend = '0;
    m_code = '0;
    m_valid = 1'b0;
    m_ovf = 1'b0;
  endtask

  // Reference: events appear S+1 edges after sampling; one offer at a time, fixed priority A>B>C>D
  task automatic model_step(input bit [3:0] r, input bit rdy);
    bit [3:0] ev, rem;
    bit hs;
    hist.push_front(r);
    ev = hist[S+1] & ~hist[S+2];
    void'(hist.pop_back());
    hs = m_valid && rdy;
    rem = m_pend;
    if (hs) rem[m_code] = 1'b0;
    for (int i = 0; i < 4; i++) if (ev[i] && rem[i]) m_ovf = 1'b1;
    if (!m_valid || hs) begin
      m_valid = 1'b0;
      for (int i = 0; i < 4; i++) if (rem[i]) begin
        m_valid = 1'b1;
        m_code = 2'(i);
      end
    end
    m_pend = rem | ev;
  endtask

  initial begin
    bus.READY = 1'b0;
    drive(4'b0000);
    tbl = '{'{4'b1000, 2'b11}, '{4'b0100, 2'b10}, '{4'b0010, 2'b01}, '{4'b0001, 2'b00},
            '{4'b0110, 2'b10}, '{4'b1111, 2'b11}, '{4'b0011, 2'b01}, '{4'b0101, 2'b10}};
    rst();
    chk_st("reset", 4'b0000, 1'b0, 1'b0);
    chk_code("reset", 2'b00);

    foreach (tbl[k]) begin
      rst();
      drive(tbl[k].req);
      tick(S + 3);
      chk_st($sformatf("vec%0d", k), tbl[k].req, 1'b1, 1'b0);
      chk_code($sformatf("vec%0d", k), tbl[k].code);
    end

    rst();
    bus.READY = 1'b1;
    drive(4'b0010);
    tick(S + 1);
    chk_st("c_pulse early", 4'b0000, 1'b0, 1'b0);
    tick(1);
    chk_st("c_pulse pend", 4'b0010, 1'b0, 1'b0);
    tick(1);
    chk_st("c_pulse offer", 4'b0010, 1'b1, 1'b0);
    chk_code("c_pulse offer", 2'b01);
    tick(1);
    chk_st("c_pulse done", 4'b0000, 1'b0, 1'b0);
    tick(4);
    chk_st("c_pulse held", 4'b0000, 1'b0, 1'b0);
    drive(4'b0000);

    rst();
    drive(4'b0011);
    tick(S + 3);
    chk_code("cd first", 2'b01);
    tick(3);
    chk_st("cd hold", 4'b0011, 1'b1, 1'b0);
    chk_code("cd hold", 2'b01);
    bus.READY = 1'b1;
    tick(1);
    bus.READY = 1'b0;
    chk_st("cd second", 4'b0001, 1'b1, 1'b0);
    chk_code("cd second", 2'b00);
    tick(2);
    chk_code("cd second hold", 2'b00);
    bus.READY = 1'b1;
    tick(1);
    bus.READY = 1'b0;
    chk_st("cd empty", 4'b0000, 1'b0, 1'b0);

    rst();
    drive(4'b0001);
    tick(S + 3);
    chk_code("d_then_a d", 2'b00);
    drive(4'b1001);
    tick(S + 4);
    chk_st("d_then_a stable", 4'b1001, 1'b1, 1'b0);
    chk_code("d_then_a stable", 2'b00);
    bus.READY = 1'b1;
    tick(1);
    chk_st("d_then_a a", 4'b1000, 1'b1, 1'b0);
    chk_code("d_then_a a", 2'b11);
    tick(1);
    chk_st("d_then_a empty", 4'b0000, 1'b0, 1'b0);

    rst();
    drive(4'b0100);
    tick(4);
    drive(4'b0000);
    tick(4);
    drive(4'b0100);
    tick(S + 3);
    chk_st("b_ovf", 4'b0100, 1'b1, 1'b1);
    chk_code("b_ovf", 2'b10);
    bus.READY = 1'b1;
    tick(1);
    chk_st("b_ovf served", 4'b0000, 1'b0, 1'b1);
    tick(3);
    chk_st("b_ovf single", 4'b0000, 1'b0, 1'b1);

    rst();
    drive(4'b1000);
    tick(S + 3);
    chk_st("rst_mid pre", 4'b1000, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk_st("rst_mid async", 4'b0000, 1'b0, 1'b0);
    chk_code("rst_mid async", 2'b00);
    tick(2);
    reset_n = 1'b1;
    tick(S + 2);
    chk_st("rst_mid held line", 4'b1000, 1'b0, 1'b0);
    tick(1);
    chk_code("rst_mid held line", 2'b11);

    rst();
    bus.READY = 1'b1;
    drive(4'b0100);
    tick(1);
    drive(4'b0000);
    tick(1);
    drive(4'b0100);
    tick(1);
    drive(4'b0000);
    tick(2);
    chk_st("b_rearm offer", 4'b0100, 1'b1, 1'b0);
    chk_code("b_rearm offer", 2'b10);
    tick(1);
    chk_st("b_rearm kept", 4'b0100, 1'b0, 1'b0);
    tick(1);
    chk_st("b_rearm again", 4'b0100, 1'b1, 1'b0);
    chk_code("b_rearm again", 2'b10);
    tick(1);
    chk_st("b_rearm done", 4'b0000, 1'b0, 1'b0);

    rst();
    for (int t = 0; t < 400; t++) begin
      logic [3:0] r;
      r = {bus.A, bus.B, bus.C, bus.D};
      for (int i = 0; i < 4; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
      drive(r);
      bus.READY = $urandom_range(1) == 1;
      @(posedge clk);
      model_step(r, bus.READY);
      @(negedge clk);
      chk_st($sformatf("rand%0d", t), m_pend, m_valid, m_ovf);
      if (m_valid) chk_code($sformatf("rand%0d", t), m_code);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
